game_round_ctrl: RTL and testbench



---
 rtl/game_round_ctrl.sv | 174 +++++++++++++++++
 tb/tb_game_round_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: sequences one game round while the top-level game FSM is in GAME.
// Loads lives/score/time on round entry, then counts a 1 s tick enable derived from clk,
// applies hit/miss pulses, and reports the outcome on W_or_L (01 lost, 10 won).
// Everything runs on clk; the one-second timebase is a prescaler, not a divided clock.
module game_round_ctrl #(
  parameter int TICK_DIV     = 27000000,
  parameter int ROUND_SEC0   = 60,
  parameter int LVL_STEP_SEC = 15,
  parameter int LIVES_INIT   = 3,
  parameter int TARGET       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] presente,
  input  logic [1:0] level_sel,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] W_or_L,
  output logic [2:0] lives,
  output logic [7:0] score,
  output logic [6:0] time_left,
  output logic       tick_1s,
  output logic       round_active
);

  localparam logic [2:0] P_OFF  = 3'd0;
  localparam logic [2:0] P_GAME = 3'd3;
  localparam logic [2:0] P_WL   = 3'd4;

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOST = 2'b01;
  localparam logic [1:0] RES_WON  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    prev_presente;
  logic [PW-1:0] presc;

  logic          round_entry;
  logic          round_exit;
  logic          tick_now;
  logic [2:0]    lives_next;
  logic [7:0]    score_next;

  // Round length for a difficulty level: each level step shortens the round.
  function automatic logic [6:0] round_len(input logic [1:0] lvl);
    int secs;
    secs = ROUND_SEC0 - LVL_STEP_SEC * int'(lvl);
    return 7'(secs);
  endfunction

  // Lives never wrap below zero.
  function automatic logic [2:0] sat_dec_lives(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Score never wraps past its maximum code.
  function automatic logic [7:0] sat_inc_score(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Seconds never wrap below zero.
  function automatic logic [6:0] sat_dec_sec(input logic [6:0] v);
    return (v == 7'd0) ? 7'd0 : v - 7'd1;
  endfunction

  // Entry/exit detection and the candidate next values for the current PLAY cycle.
  always_comb begin
    round_entry = (presente == P_GAME) && (prev_presente != P_GAME);
    round_exit  = (presente != P_GAME) && (presente != P_WL);
    tick_now    = (presc == PW'(TICK_DIV - 1));
    lives_next  = miss ? sat_dec_lives(lives) : lives;
    score_next  = hit ? sat_inc_score(score) : score;
  end

  // Round sequencer: state, prescaler and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      prev_presente <= P_OFF;
      presc         <= '0;
      W_or_L        <= RES_NONE;
      lives         <= 3'd0;
      score         <= 8'd0;
      time_left     <= 7'd0;
      tick_1s       <= 1'b0;
      round_active  <= 1'b0;
    end else begin
      prev_presente <= presente;
      tick_1s       <= 1'b0;
      if (round_entry) begin
        // Fresh GAME entry (CH->GAME or PA->GAME) restarts the round from any state.
        state        <= S_LOAD;
        round_active <= 1'b0;
        presc        <= '0;
      end else if (round_exit) begin
        // OFF/WLCM/CH/PA: drop the round and clear everything visible.
        state        <= S_IDLE;
        presc        <= '0;
        W_or_L       <= RES_NONE;
        lives        <= 3'd0;
        score        <= 8'd0;
        time_left    <= 7'd0;
        round_active <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            presc <= '0;
          end
          S_LOAD: begin
            lives        <= 3'(LIVES_INIT);
            score        <= 8'd0;
            time_left    <= round_len(level_sel);
            W_or_L       <= RES_NONE;
            presc        <= '0;
            round_active <= 1'b1;
            state        <= S_PLAY;
          end
          S_PLAY: begin
            if (presente == P_WL) begin
              // Leaving GAME without a result: freeze as if the round had ended.
              state        <= S_DONE;
              round_active <= 1'b0;
              presc        <= '0;
            end else begin
              lives <= lives_next;
              score <= score_next;
              if (tick_now) begin
                presc     <= '0;
                tick_1s   <= 1'b1;
                time_left <= sat_dec_sec(time_left);
              end else begin
                presc <= presc + PW'(1);
              end
              // Loss by lives beats a win in the same cycle; timeout is last.
              if (lives_next == 3'd0) begin
                W_or_L       <= RES_LOST;
                state        <= S_DONE;
                round_active <= 1'b0;
                presc        <= '0;
              end else if (score_next == 8'(TARGET)) begin
                W_or_L       <= RES_WON;
                state        <= S_DONE;
                round_active <= 1'b0;
                presc        <= '0;
              end else if (tick_now && (time_left == 7'd1)) begin
                W_or_L       <= RES_LOST;
                state        <= S_DONE;
                round_active <= 1'b0;
                presc        <= '0;
              end
            end
          end
          S_DONE: begin
            presc        <= '0;
            round_active <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: scoreboard bench for game_round_ctrl with a behavioural round model.
module tb_game_round_ctrl;

  localparam int TICK_DIV     = 10;
  localparam int ROUND_SEC0   = 60;
  localparam int LVL_STEP_SEC = 15;
  localparam int LIVES_INIT   = 3;
  localparam int TARGET       = 20;

  logic       clk;
  logic       rst_n;
  logic [2:0] presente;
  logic [1:0] level_sel;
  logic       hit;
  logic       miss;
  logic [1:0] W_or_L;
  logic [2:0] lives;
  logic [7:0] score;
  logic [6:0] time_left;
  logic       tick_1s;
  logic       round_active;

  game_round_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .ROUND_SEC0  (ROUND_SEC0),
    .LVL_STEP_SEC(LVL_STEP_SEC),
    .LIVES_INIT  (LIVES_INIT),
    .TARGET      (TARGET)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .presente    (presente),
    .level_sel   (level_sel),
    .hit         (hit),
    .miss        (miss),
    .W_or_L      (W_or_L),
    .lives       (lives),
    .score       (score),
    .time_left   (time_left),
    .tick_1s     (tick_1s),
    .round_active(round_active)
  );

  typedef struct packed {
    logic [1:0] wl;
    logic [2:0] lives;
    logic [7:0] score;
    logic [6:0] tl;
    logic       tick;
    logic       act;
  } obs_t;

  obs_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Behavioural model: round phase flags, a count of cycles spent playing, visible values.
  bit   m_loading;
  bit   m_playing;
  int   m_play_cycles;
  int   m_prev;
  obs_t m_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_out         = '0;
    m_loading     = 1'b0;
    m_playing     = 1'b0;
    m_play_cycles = 0;
    m_prev        = 0;
  endtask

  // One clock of the round rules, using the inputs seen at that edge.
  task automatic model_step(input int p, input int lvl, input bit h, input bit m);
    bit second_done;
    int new_lives, new_score, old_time, result;
    m_out.tick = 1'b0;
    if (p == 3 && m_prev != 3) begin
      m_loading  = 1'b1;
      m_playing  = 1'b0;
      m_out.act  = 1'b0;
    end else if (p != 3 && p != 4) begin
      m_out     = '0;
      m_loading = 1'b0;
      m_playing = 1'b0;
    end else if (m_loading) begin
      m_loading     = 1'b0;
      m_playing     = 1'b1;
      m_play_cycles = 0;
      m_out.lives   = 3'(LIVES_INIT);
      m_out.score   = 8'd0;
      m_out.tl      = 7'(ROUND_SEC0 - LVL_STEP_SEC * lvl);
      m_out.wl      = 2'd0;
      m_out.act     = 1'b1;
    end else if (m_playing) begin
      if (p == 4) begin
        m_playing = 1'b0;
        m_out.act = 1'b0;
      end else begin
        second_done   = ((m_play_cycles % TICK_DIV) == TICK_DIV - 1);
        m_play_cycles = m_play_cycles + 1;
        new_lives     = int'(m_out.lives) - (m ? 1 : 0);
        if (new_lives < 0) new_lives = 0;
        new_score     = int'(m_out.score) + (h ? 1 : 0);
        old_time      = int'(m_out.tl);
        m_out.lives   = 3'(new_lives);
        m_out.score   = 8'(new_score);
        if (second_done) begin
          m_out.tick = 1'b1;
          m_out.tl   = 7'(old_time - 1);
        end
        result = 0;
        if (new_lives == 0) result = 1;
        else if (new_score == TARGET) result = 2;
        else if (second_done && old_time == 1) result = 1;
        if (result != 0) begin
          m_out.wl  = 2'(result);
          m_playing = 1'b0;
          m_out.act = 1'b0;
        end
      end
    end
    m_prev = p;
  endtask

  // Drive one cycle of stimulus, then queue the expected post-edge outputs.
  task automatic step(input int p, input int lvl, input bit h, input bit m);
    presente  = 3'(p);
    level_sel = 2'(lvl);
    hit       = h;
    miss      = m;
    @(posedge clk);
    if (rst_n) model_step(p, lvl, h, m);
    else model_reset();
    q.push_back(m_out);
    #1;
    hit  = 1'b0;
    miss = 1'b0;
  endtask

  task automatic idle(input int n, input int p, input int lvl);
    for (int i = 0; i < n; i++) step(p, lvl, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges: outputs must drop before the next clock.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    q[q.size() - 1] = m_out;
  endtask

  // Monitor: compares the DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin : monitor
    obs_t e;
    obs_t a;
    cyc = cyc + 1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {W_or_L, lives, score, time_left, tick_1s, round_active};
      total = total + 1;
      if (a !== e) begin
        bad = bad + 1;
        $display("FAIL outputs cyc=%0d got wl=%0d lives=%0d score=%0d tl=%0d tick=%0d act=%0d want wl=%0d lives=%0d score=%0d tl=%0d tick=%0d act=%0d",
                 cyc, a.wl, a.lives, a.score, a.tl, a.tick, a.act,
                 e.wl, e.lives, e.score, e.tl, e.tick, e.act);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n     = 1'b0;
    presente  = 3'd0;
    level_sel = 2'd0;
    hit       = 1'b0;
    miss      = 1'b0;
    model_reset();

    // Reset state
    idle(3, 2, 0);
    rst_n = 1'b1;
    idle(2, 2, 0);

    // Level 0 round: load, two ticks, then 20 hits with random gaps, then an extra hit
    idle(30, 3, 0);
    for (int i = 0; i < TARGET; i++) begin
      step(3, 0, 1'b1, 1'b0);
      idle($urandom_range(0, 4), 3, 0);
    end
    step(3, 0, 1'b1, 1'b0);
    idle(4, 3, 0);
    idle(3, 4, 0);
    idle(2, 5, 0);

    // Loss by three misses, result held in WL, cleared in PA
    idle(3, 3, 0);
    for (int i = 0; i < LIVES_INIT; i++) begin
      step(3, 0, 1'b0, 1'b1);
      idle($urandom_range(0, 5), 3, 0);
    end
    idle(3, 3, 0);
    idle(3, 4, 0);
    idle(2, 5, 0);

    // Simultaneous hit and miss at score=19, lives=1: loss wins
    idle(3, 3, 1);
    for (int i = 0; i < TARGET - 1; i++) begin
      step(3, 1, 1'b1, 1'b0);
      idle($urandom_range(0, 2), 3, 1);
    end
    for (int i = 0; i < LIVES_INIT - 1; i++) begin
      step(3, 1, 1'b0, 1'b1);
      idle($urandom_range(0, 2), 3, 1);
    end
    step(3, 1, 1'b1, 1'b1);
    idle(3, 3, 1);
    idle(2, 4, 1);
    idle(2, 5, 1);

    // Level 3 timeout, then PA->GAME reload
    idle(165, 3, 3);
    idle(2, 4, 3);
    idle(2, 5, 3);
    idle(14, 3, 3);

    // Power off mid-round
    idle(3, 0, 3);

    // Async reset mid-round, then restart with a fresh prescaler
    idle(2, 2, 2);
    idle(17, 3, 2);
    async_reset();
    idle(2, 3, 2);
    rst_n = 1'b1;
    idle(2, 2, 2);
    idle(27, 3, 2);
    idle(2, 0, 0);

    // Randomized rounds with occasional presente excursions
    for (int r = 0; r < 8; r++) begin
      int lvl;
      lvl = $urandom_range(0, 3);
      idle(2, 2, lvl);
      for (int c = 0; c < 160; c++) begin
        int roll, p;
        roll = $urandom_range(0, 299);
        if (roll == 0) p = 0;
        else if (roll == 1) p = 4;
        else if (roll == 2) p = 5;
        else p = 3;
        step(p, lvl, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      end
      idle(3, 4, lvl);
      idle(2, 5, lvl);
    end

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
